// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Groups the instruction-fetch signals: the NPC loop, the redirect and stall
// inputs from later stages, the instruction-memory request/response channel,
// and the IF/ID pipeline register outputs.
//   master : fetch unit side (drives pc_out, imem_req/addr, ifid_*)
//   slave  : environment side (drives npc_in, flush*, id_stall, imem_ready,
//            imem_rvalid, imem_rdata)
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic [31:0] pc_out;
    logic [31:0] npc_in;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;

    modport master (
        output pc_out, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_inst,
        input  npc_in, flush, flush_pc, id_stall, imem_ready, imem_rvalid, imem_rdata
    );

    modport slave (
        input  pc_out, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_inst,
        output npc_in, flush, flush_pc, id_stall, imem_ready, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: keeps the fetch PC, issues one instruction-memory
// request at a time, and writes the returned word into the IF/ID register.
// A decode stall parks a returned word in a one-entry hold buffer; a flush
// redirects the PC and marks any in-flight response to be dropped.
// Ports:
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   io_fetch  : if_fetch_unit_if.master (NPC loop, flush/stall, imem, IF/ID)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_unit_if.master   io_fetch
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_drop;
    logic        w_drop_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_inst;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_inst;

    logic        w_flush;
    logic        w_stall;
    logic        w_resp;
    logic        w_capture;
    logic        w_deliver_mem;
    logic        w_deliver_hold;
    logic        w_deliver;
    logic [31:0] w_deliver_pc;
    logic [31:0] w_deliver_inst;

    assign w_flush = io_fetch.flush;
    assign w_stall = io_fetch.id_stall;

    // rvalid is only meaningful while a request is outstanding; a stray
    // strobe from a request issued before reset is ignored in REQ/HOLD.
    assign w_resp         = (r_state == S_WAIT) && io_fetch.imem_rvalid;
    assign w_deliver_mem  = w_resp && !r_drop && !w_flush && !w_stall;
    assign w_capture      = w_resp && !r_drop && !w_flush &&  w_stall;
    assign w_deliver_hold = (r_state == S_HOLD) && !w_flush && !w_stall;
    assign w_deliver      = w_deliver_mem || w_deliver_hold;
    assign w_deliver_pc   = w_deliver_hold ? r_hold_pc   : r_pc;
    assign w_deliver_inst = w_deliver_hold ? r_hold_inst : io_fetch.imem_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            S_REQ: begin
                // A flush in the same cycle the request is accepted still
                // lets the old-PC request go out, so its response must be dropped.
                if (io_fetch.imem_ready) begin
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = w_flush;
                end
            end
            S_WAIT: begin
                if (io_fetch.imem_rvalid) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = w_capture ? S_HOLD : S_REQ;
                end else if (w_flush) begin
                    w_drop_nxt  = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_flush || !w_stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
                w_drop_nxt  = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        io_fetch.imem_req = (r_state == S_REQ);
    end

    assign io_fetch.imem_addr  = r_pc;
    assign io_fetch.pc_out     = r_pc;
    assign io_fetch.ifid_valid = r_ifid_valid;
    assign io_fetch.ifid_pc    = r_ifid_pc;
    assign io_fetch.ifid_inst  = r_ifid_inst;

    // PC, IF/ID register and hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'h0;
            r_ifid_inst  <= 32'h0;
            r_hold_pc    <= 32'h0;
            r_hold_inst  <= 32'h0;
        end else begin
            if (w_flush) begin
                r_pc         <= io_fetch.flush_pc;
                r_ifid_valid <= 1'b0;
                r_hold_pc    <= 32'h0;
                r_hold_inst  <= 32'h0;
            end else begin
                if (w_deliver) begin
                    r_pc         <= io_fetch.npc_in;
                    r_ifid_valid <= 1'b1;
                    r_ifid_pc    <= w_deliver_pc;
                    r_ifid_inst  <= w_deliver_inst;
                end else if (!w_stall) begin
                    r_ifid_valid <= 1'b0;
                end
                if (w_capture) begin
                    r_hold_pc   <= r_pc;
                    r_hold_inst <= io_fetch.imem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Drives the fetch unit with a variable-latency instruction memory, random
// flushes, stalls and resets, and compares every cycle against a
// transaction-level model (outstanding request flag, drop flag, queue of
// parked PCs). Instruction words are a fixed hash of their address.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    if_fetch_unit_if bus ();

    assign bus.npc_in = bus.pc_out + 32'd4;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_fetch (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // reference model state
    bit          m_known = 1'b0;
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_buf[$];
    bit          m_ifid_valid;
    logic [31:0] m_ifid_pc;

    // memory model state
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;
    int          lat_max  = 0;
    bit          spur_en  = 1'b0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit do_rst, input bit do_flush, input logic [31:0] fpc,
                        input bit stall, input bit rdy);
        bit          exp_req;
        bit          rv;
        bit          deliver;
        logic [31:0] dpc;
        @(negedge clk);
        exp_req = !m_out && (m_buf.size() == 0);
        if (m_known) begin
            chk("pc_out", bus.pc_out, m_pc);
            chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
            if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
            chk("ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_ifid_valid});
            if (m_ifid_valid) begin
                chk("ifid_pc", bus.ifid_pc, m_ifid_pc);
                chk("ifid_inst", bus.ifid_inst, inst_of(m_ifid_pc));
            end
        end

        // drive inputs for the coming edge
        rst = do_rst;
        bus.flush = do_flush;
        bus.flush_pc = fpc;
        bus.id_stall = stall;
        bus.imem_ready = rdy;
        if (mem_pend && mem_cnt == 0) begin
            rv = 1'b1;
            bus.imem_rdata = inst_of(mem_addr);
        end else begin
            rv = !mem_pend && spur_en && ($urandom_range(0, 7) == 0);
            bus.imem_rdata = $urandom;
        end
        bus.imem_rvalid = rv;

        // reference model: effect of this edge
        deliver = 1'b0;
        dpc = 32'h0;
        if (do_rst) begin
            m_pc = RESET_PC;
            m_out = 1'b0;
            m_drop = 1'b0;
            m_buf.delete();
            m_ifid_valid = 1'b0;
            m_ifid_pc = 32'h0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (m_buf.size() > 0) begin
                if (do_flush) m_buf.delete();
                else if (!stall) begin
                    deliver = 1'b1;
                    dpc = m_buf[0];
                    m_buf.delete();
                end
            end else if (m_out) begin
                if (rv) begin
                    m_out = 1'b0;
                    if (m_drop) m_drop = 1'b0;
                    else if (!do_flush) begin
                        if (stall) m_buf.push_back(m_pc);
                        else begin
                            deliver = 1'b1;
                            dpc = m_pc;
                        end
                    end
                end else if (do_flush) begin
                    m_drop = 1'b1;
                end
            end else if (rdy) begin
                m_out = 1'b1;
                m_drop = do_flush;
            end
            if (do_flush) begin
                m_ifid_valid = 1'b0;
                m_pc = fpc;
            end else if (deliver) begin
                m_ifid_valid = 1'b1;
                m_ifid_pc = dpc;
                m_pc = m_pc + 32'd4;
            end else if (!stall) begin
                m_ifid_valid = 1'b0;
            end
        end

        // memory: one response per accepted request, reset alongside the DUT
        if (do_rst) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt == 0) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        else if (bus.imem_req === 1'b1 && rdy) begin
            mem_pend = 1'b1;
            mem_addr = bus.imem_addr;
            mem_cnt = $urandom_range(0, lat_max);
        end
    endtask

    initial begin
        logic [31:0] tmp;
        logic [31:0] fpc;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.flush_pc = 32'h0;
        bus.id_stall = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;

        // reset, then zero-wait streaming from RESET_PC
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (12) step(0, 0, 0, 0, 1);

        // decode stall for three cycles around a response
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 1, 1);
        repeat (6) step(0, 0, 0, 0, 1);

        // flush while a request is outstanding, then flush while holding
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'h0000_0100, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_0200, 1, 1);
        repeat (6) step(0, 0, 0, 0, 1);

        // PC wraps past 0xFFFF_FFFC
        step(0, 1, 32'hFFFF_FFF8, 0, 1);
        repeat (10) step(0, 0, 0, 0, 1);

        // reset while waiting for a response
        for (int k = 0; k < 4 && !m_out; k++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 1);

        // randomized traffic
        lat_max = 2;
        spur_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tmp = $urandom;
            if ($urandom_range(0, 3) == 0) fpc = 32'hFFFF_FFF0 | (tmp & 32'hC);
            else fpc = tmp & 32'hFFFF_FFFC;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) == 0,
                 fpc,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 0);
        end
        step(0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: pc_out  output  32  current fetch PC; drives the PC input of the NPC block.
REQ-005 Port: npc_in  input  32  next PC from the NPC block, combinationally derived from pc_out.
REQ-006 Port: flush  input  1  taken branch, jump or jalr resolved downstream; redirects fetch.
REQ-007 Port: flush_pc  input  32  redirect target, valid when flush=1.
REQ-008 Port: id_stall  input  1  decode cannot accept; IF/ID holds its contents.
REQ-009 Port: imem_req / imem_addr  output  1 / 32  instruction memory request and word address (= pc_out).
REQ-010 Port: imem_ready  input  1  request accepted this cycle when imem_req=1.
REQ-011 Port: imem_rvalid / imem_rdata  input  1 / 32  response strobe and instruction word, at least 1 cycle after acceptance.
REQ-012 Port: ifid_valid / ifid_pc / ifid_inst  output  1 / 32 / 32  IF/ID pipeline register contents.

Function
REQ-013 FSM states REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-014 REQ: imem_req=1, imem_addr=pc_out; imem_ready=1 -> WAIT; otherwise stay in REQ. imem_req=0 in WAIT and HOLD.
REQ-015 WAIT, imem_rvalid=1, no drop pending, flush=0, id_stall=0: IF/ID <= {1, pc_out, imem_rdata}; pc_out <= npc_in; -> REQ.
REQ-016 WAIT, imem_rvalid=1, no drop pending, flush=0, id_stall=1: capture {pc_out, imem_rdata} into hold buffer; IF/ID unchanged; -> HOLD.
REQ-017 HOLD, id_stall=0, flush=0: IF/ID <= {1, buffered pc, buffered inst}; pc_out <= npc_in; -> REQ.
REQ-018 flush=1 has priority over every other event: ifid_valid <= 0, pc_out <= flush_pc, hold buffer discarded.
REQ-019 flush in REQ with imem_ready=0: pc_out <= flush_pc, stay REQ (no request issued to old PC).
REQ-020 flush in REQ with imem_ready=1, or in WAIT without imem_rvalid: set drop_pending; -> WAIT (or stay in WAIT).
REQ-021 flush in WAIT coincident with imem_rvalid, or in HOLD: response/buffer discarded, drop_pending cleared, -> REQ.
REQ-022 WAIT with drop_pending and imem_rvalid=1: response discarded, drop_pending <= 0, -> REQ; IF/ID and pc_out unaffected unless flush also asserted.
REQ-023 id_stall=1 and flush=0: IF/ID holds all fields unchanged.
REQ-024 id_stall=0, flush=0, no instruction delivered this cycle: ifid_valid <= 0 (bubble); ifid_pc/ifid_inst don't-care.
REQ-025 pc_out changes only on delivery to IF/ID (REQ-015/017), flush, or reset; never while a non-dropped request is outstanding.
REQ-026 PC arithmetic is 32-bit, wraps modulo 2^32; no alignment check.
REQ-027 Throughput: with imem_ready=1 and rvalid one cycle after acceptance, one instruction per 2 cycles.

Reset
REQ-028 rst=1 at a clock edge: pc_out <= RESET_PC, state <= REQ, drop_pending <= 0, ifid_valid <= 0, ifid_pc <= 0, ifid_inst <= 0, hold buffer cleared.
REQ-029 Reset mid-transaction: a later imem_rvalid for a pre-reset request is ignored while not in WAIT; the memory is reset alongside.
REQ-030 First imem_req=1 with imem_addr=RESET_PC occurs in the first cycle after rst deasserts.

Verification
REQ-031 Reset, zero-wait memory, npc_in=pc_out+4 -> ifid_pc 0x0, 0x4, 0x8 every 2 cycles, matching imem_rdata.
REQ-032 id_stall=1 for 3 cycles at rvalid of PC 0x8 -> HOLD; IF/ID keeps PC 0x4; at release ifid_pc=0x8; pc_out then 0xC.
REQ-033 flush=1, flush_pc=0x100 in WAIT before rvalid -> ifid_valid=0; next response dropped; next request addr=0x100.
REQ-034 flush=1, flush_pc=0x200 in HOLD -> buffered instruction never reaches IF/ID; next imem_addr=0x200.
REQ-035 pc_out=0xFFFF_FFFC, npc_in=pc_out+4 -> next request addr 0x0000_0000.
REQ-036 rst=1 while in WAIT -> next cycle pc_out=RESET_PC, ifid_valid=0, imem_req=1.
